// File: rtl/seg7_pkg.sv
// Shared constants for the ASCII 7-segment display stage: blank/dash codes,
// glyph tables (bit0=a .. bit6=g, active-high) and the sequencer state type.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  localparam logic [6:0] DIGIT_GLYPH [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Best-effort letters A..Z; some shapes are lower-case forms (b, d, n, r) or shared (H/X).
  localparam logic [6:0] LETTER_GLYPH [26] = '{
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h30, 7'h1E,
    7'h75, 7'h38, 7'h37, 7'h54, 7'h3F, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78,
    7'h3E, 7'h1C, 7'h2A, 7'h76, 7'h6E, 7'h5B
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  function automatic logic [7:0] fold_upper(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) begin
      return c - 8'h20;
    end else begin
      return c;
    end
  endfunction

endpackage

// File: rtl/ascii_to_seg7.sv
// Combinational ASCII to 7-segment decoder. Lower-case folds to upper-case;
// anything without a glyph shows a dash. Only '.' lights the decimal point.
module ascii_to_seg7
  import seg7_pkg::*;
(
  input  logic [7:0] ch,
  output logic [6:0] seg,
  output logic       dp
);

  logic [7:0] up_s;
  logic [3:0] digit_idx_s;
  logic [4:0] letter_idx_s;

  // Glyph lookup on the case-folded character
  always_comb begin
    up_s         = fold_upper(ch);
    digit_idx_s  = 4'(up_s - 8'h30);
    letter_idx_s = 5'(up_s - 8'h41);
    seg          = SEG_DASH;
    dp           = 1'b0;
    if (up_s >= 8'h30 && up_s <= 8'h39) begin
      seg = DIGIT_GLYPH[digit_idx_s];
    end else if (up_s >= 8'h41 && up_s <= 8'h5A) begin
      seg = LETTER_GLYPH[letter_idx_s];
    end else if (up_s == 8'h20) begin
      seg = SEG_BLANK;
    end else if (up_s == 8'h2E) begin
      seg = SEG_BLANK;
      dp  = 1'b1;
    end else begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/ascii_seg7_sequencer.sv
// Display sequencer: accepts one character per handshake, lights its glyph for
// HOLD_CYCLES, then blanks for GAP_CYCLES before accepting the next one.
module ascii_seg7_sequencer
  import seg7_pkg::*;
#(
  parameter int HOLD_CYCLES = 12_000_000,
  parameter int GAP_CYCLES  = 1_200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clear,
  input  logic [7:0] in_char,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       busy
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_t           state_r, state_d_s;
  logic [CNT_W-1:0] cnt_r, cnt_d_s;
  logic [7:0]       char_r, char_d_s;
  logic [6:0]       seg_r, dec_seg_s;
  logic             dp_r, dec_dp_s;
  logic             busy_r;
  logic             accept_s;

  assign in_ready = (state_r == S_IDLE) && en && !clear;
  assign accept_s = in_ready && in_valid;

  // Next-state, counter and character-latch logic
  always_comb begin
    state_d_s = state_r;
    cnt_d_s   = cnt_r;
    char_d_s  = char_r;
    if (clear) begin
      state_d_s = S_IDLE;
      cnt_d_s   = CNT_ZERO;
    end else if (!en) begin
      state_d_s = state_r;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            char_d_s  = in_char;
            cnt_d_s   = HOLD_LOAD;
            state_d_s = S_SHOW;
          end else begin
            state_d_s = S_IDLE;
          end
        end
        S_SHOW: begin
          if (cnt_r == CNT_ZERO) begin
            if (GAP_CYCLES == 0) begin
              state_d_s = S_IDLE;
              cnt_d_s   = CNT_ZERO;
            end else begin
              state_d_s = S_GAP;
              cnt_d_s   = GAP_LOAD;
            end
          end else begin
            cnt_d_s = cnt_r - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_r == CNT_ZERO) begin
            state_d_s = S_IDLE;
          end else begin
            cnt_d_s = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_d_s = S_IDLE;
          cnt_d_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Decoding the next char value lets the pattern register light in the cycle after accept
  ascii_to_seg7 u_decode (
    .ch  (char_d_s),
    .seg (dec_seg_s),
    .dp  (dec_dp_s)
  );

  // State, counter, char and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
      char_r  <= 8'h00;
      seg_r   <= SEG_BLANK;
      dp_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_d_s;
      cnt_r   <= cnt_d_s;
      char_r  <= char_d_s;
      seg_r   <= (state_d_s == S_SHOW) ? dec_seg_s : SEG_BLANK;
      dp_r    <= (state_d_s == S_SHOW) ? dec_dp_s : 1'b0;
      busy_r  <= (state_d_s != S_IDLE);
    end
  end

  assign seg_out = seg_r;
  assign dp_out  = dp_r;
  assign busy    = busy_r;

endmodule
